// File: rtl/mig_pkg.sv
// Shared encodings for the majority-inverter truth-table engine.
package mig_pkg;

  // Widest operand selector a node entry can hold (1 + NUM_IN + MAX_NODES <= 256).
  localparam int unsigned SEL_MAX_W   = 8;

  // Signal index map: 0 = constant 0, 1..NUM_IN = inputs, NUM_IN+1+k = node k.
  localparam int unsigned SIG_CONST0  = 0;
  localparam int unsigned SIG_IN_BASE = 1;

  function automatic int unsigned sig_node_base(input int unsigned num_in);
    return num_in + 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One majority node: three operand selectors and their complement bits.
  typedef struct packed {
    logic                 neg_c;
    logic                 neg_b;
    logic                 neg_a;
    logic [SEL_MAX_W-1:0] sel_c;
    logic [SEL_MAX_W-1:0] sel_b;
    logic [SEL_MAX_W-1:0] sel_a;
  } node_entry_t;

endpackage

// File: rtl/mig_maj3.sv
// Bitwise three-input majority over full truth tables, each input optionally complemented.
module mig_maj3 #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic         neg_a,
  input  logic         neg_b,
  input  logic         neg_c,
  output logic [W-1:0] maj_c
);

  logic [W-1:0] ax;
  logic [W-1:0] bx;
  logic [W-1:0] cx;

  // Apply complements, then take the majority of each bit column.
  always_comb begin
    ax    = a ^ {W{neg_a}};
    bx    = b ^ {W{neg_b}};
    cx    = c ^ {W{neg_c}};
    maj_c = (ax & bx) | (ax & cx) | (bx & cx);
  end

endmodule

// File: rtl/mig_tt_engine.sv
// Evaluates a programmed majority-inverter network one node per cycle into a truth table.
// cfg_node layout: [SEL_W-1:0]=sel a, [2*SEL_W-1:SEL_W]=sel b, [3*SEL_W-1:2*SEL_W]=sel c,
// then neg a, neg b, neg c in the top three bits. cfg_out = {neg, sel}.
module mig_tt_engine
  import mig_pkg::*;
#(
  parameter  int unsigned NUM_IN    = 7,
  parameter  int unsigned MAX_NODES = 16,
  localparam int unsigned TT_W      = 2 ** NUM_IN,
  localparam int unsigned SEL_W     = $clog2(1 + NUM_IN + MAX_NODES),
  localparam int unsigned AW        = $clog2(MAX_NODES),
  localparam int unsigned NW        = $clog2(MAX_NODES + 1),
  localparam int unsigned NODE_W    = 3 * SEL_W + 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [NODE_W-1:0] cfg_node,
  input  logic [NW-1:0]     cfg_num_nodes,
  input  logic [SEL_W:0]    cfg_out,
  input  logic              start,
  output logic              busy,
  output logic [TT_W-1:0]   tt,
  output logic              tt_err,
  output logic              tt_valid,
  input  logic              tt_ready
);

  state_t                 state_q;
  state_t                 state_nx;
  node_entry_t            node_cfg [MAX_NODES];
  logic [TT_W-1:0]        node_tt  [MAX_NODES];
  logic [TT_W-1:0]        proj     [NUM_IN];
  logic [AW-1:0]          cnt_q;
  logic [NW-1:0]          num_q;
  logic [SEL_MAX_W-1:0]   out_sel_q;
  logic                   out_neg_q;
  node_entry_t            wr_entry;
  node_entry_t            cur;
  logic [TT_W:0]          op_a;
  logic [TT_W:0]          op_b;
  logic [TT_W:0]          op_c;
  logic [TT_W:0]          out_rd;
  logic [TT_W-1:0]        maj_c;
  logic [TT_W-1:0]        out_val;
  logic                   op_err;
  logic                   last_node;
  logic                   num_over;
  logic [NW-1:0]          num_sat;

  // Resolve a selector to {err, value}; nodes at or beyond lim read as zero and flag err.
  function automatic logic [TT_W:0] read_sig(input logic [SEL_MAX_W-1:0] sel,
                                             input logic [NW-1:0]        lim);
    logic [TT_W:0] r;
    r = '0;
    if (32'(sel) == SIG_CONST0) r = '0;
    if (32'(sel) > NUM_IN + MAX_NODES) r[TT_W] = 1'b1;
    for (int unsigned i = 0; i < NUM_IN; i++)
      if (32'(sel) == SIG_IN_BASE + i) r[TT_W-1:0] = proj[i];
    for (int unsigned k = 0; k < MAX_NODES; k++)
      if (32'(sel) == sig_node_base(NUM_IN) + k) begin
        if (k < 32'(lim)) r[TT_W-1:0] = node_tt[k];
        else              r[TT_W]     = 1'b1;
      end
    return r;
  endfunction

  // Input projection patterns: bit m of input i is bit i of m.
  always_comb begin
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      proj[i] = '0;
      for (int unsigned m = 0; m < TT_W; m++) proj[i][m] = 1'((m >> i) & 1);
    end
  end

  // Unpack the configuration word and read operands for the current node and the output.
  always_comb begin
    wr_entry       = '0;
    wr_entry.sel_a = SEL_MAX_W'(cfg_node[SEL_W-1:0]);
    wr_entry.sel_b = SEL_MAX_W'(cfg_node[2*SEL_W-1:SEL_W]);
    wr_entry.sel_c = SEL_MAX_W'(cfg_node[3*SEL_W-1:2*SEL_W]);
    wr_entry.neg_a = cfg_node[3*SEL_W];
    wr_entry.neg_b = cfg_node[3*SEL_W+1];
    wr_entry.neg_c = cfg_node[3*SEL_W+2];
    cur            = node_cfg[cnt_q];
    op_a           = read_sig(cur.sel_a, NW'(cnt_q));
    op_b           = read_sig(cur.sel_b, NW'(cnt_q));
    op_c           = read_sig(cur.sel_c, NW'(cnt_q));
    op_err         = op_a[TT_W] | op_b[TT_W] | op_c[TT_W];
    out_rd         = read_sig(out_sel_q, num_q);
    out_val        = out_rd[TT_W-1:0] ^ {TT_W{out_neg_q}};
    last_node      = (NW'(cnt_q) + NW'(1)) == num_q;
    num_over       = 32'(cfg_num_nodes) > MAX_NODES;
    num_sat        = num_over ? NW'(MAX_NODES) : cfg_num_nodes;
  end

  mig_maj3 #(.W(TT_W)) u_maj (
    .a     (op_a[TT_W-1:0]),
    .b     (op_b[TT_W-1:0]),
    .c     (op_c[TT_W-1:0]),
    .neg_a (cur.neg_a),
    .neg_b (cur.neg_b),
    .neg_c (cur.neg_c),
    .maj_c (maj_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE: if (start) state_nx = (cfg_num_nodes != '0) ? ST_EVAL : ST_DONE;
      ST_EVAL: if (last_node) state_nx = ST_DONE;
      ST_DONE: if (tt_valid && tt_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Run control and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      tt        <= '0;
      tt_err    <= 1'b0;
      tt_valid  <= 1'b0;
      cnt_q     <= '0;
      num_q     <= '0;
      out_sel_q <= '0;
      out_neg_q <= 1'b0;
    end else begin
      busy <= (state_nx != ST_IDLE);
      case (state_q)
        ST_IDLE: if (start) begin
          num_q     <= num_sat;
          out_sel_q <= SEL_MAX_W'(cfg_out[SEL_W-1:0]);
          out_neg_q <= cfg_out[SEL_W];
          tt_err    <= num_over;
          cnt_q     <= '0;
        end
        ST_EVAL: begin
          tt_err <= tt_err | op_err;
          if (!last_node) cnt_q <= cnt_q + AW'(1);
        end
        ST_DONE: begin
          if (!tt_valid) begin
            tt       <= out_val;
            tt_err   <= tt_err | out_rd[TT_W];
            tt_valid <= 1'b1;
          end else if (tt_ready) begin
            tt_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Node configuration and evaluated truth tables; contents survive reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && cfg_we && 32'(cfg_addr) < MAX_NODES) node_cfg[cfg_addr] <= wr_entry;
    if (state_q == ST_EVAL) node_tt[cnt_q] <= maj_c;
  end

endmodule

// File: tb/tb_mig_tt_engine.sv
// Scoreboard bench: a 3-input and a 7-input engine share configuration inputs.
module tb_mig_tt_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_we;
  logic [3:0]   cfg_addr;
  logic [17:0]  cfg_node;
  logic [4:0]   cfg_num_nodes;
  logic [5:0]   cfg_out;
  logic         start3;
  logic         start7;
  logic         tt_ready;
  logic         busy3, err3, valid3;
  logic [7:0]   tt3;
  logic         busy7, err7, valid7;
  logic [127:0] tt7;

  typedef struct {
    logic [127:0] tt;
    logic         err;
  } exp_t;

  exp_t q3[$];
  exp_t q7[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   c_sel [16][3];
  bit   c_neg [16][3];

  mig_tt_engine #(.NUM_IN(3), .MAX_NODES(16)) dut3 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_node(cfg_node),
    .cfg_num_nodes(cfg_num_nodes), .cfg_out(cfg_out), .start(start3), .busy(busy3),
    .tt(tt3), .tt_err(err3), .tt_valid(valid3), .tt_ready(tt_ready)
  );

  mig_tt_engine #(.NUM_IN(7), .MAX_NODES(16)) dut7 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_node(cfg_node),
    .cfg_num_nodes(cfg_num_nodes), .cfg_out(cfg_out), .start(start7), .busy(busy7),
    .tt(tt7), .tt_err(err7), .tt_valid(valid7), .tt_ready(tt_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare each consumed result against the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (valid3 && tt_ready) begin
        if (q3.size() > 0) begin
          e = q3.pop_front();
          chk("tt3", 128'(tt3), e.tt);
          chk("err3", 128'(err3), 128'(e.err));
        end else chk("unexpected_valid3", 128'(valid3), 128'(0));
      end
      if (valid7 && tt_ready) begin
        if (q7.size() > 0) begin
          e = q7.pop_front();
          chk("tt7", tt7, e.tt);
          chk("err7", 128'(err7), 128'(e.err));
        end else chk("unexpected_valid7", 128'(valid7), 128'(0));
      end
    end
  end

  task automatic prog(input int a, input int s0, input int s1, input int s2,
                      input bit n0, input bit n1, input bit n2);
    c_sel[a][0] = s0; c_sel[a][1] = s1; c_sel[a][2] = s2;
    c_neg[a][0] = n0; c_neg[a][1] = n1; c_neg[a][2] = n2;
    cfg_node = {n2, n1, n0, 5'(s2), 5'(s1), 5'(s0)};
    cfg_addr = 4'(a);
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
  endtask

  // Queue the expectation, pulse start, and check the start-to-valid latency.
  task automatic run(input int d, input int num, input int osel, input bit oneg,
                     input logic [127:0] ett, input bit eerr, input int elat);
    exp_t e;
    int   lat;
    e.tt  = ett;
    e.err = eerr;
    if (d == 3) q3.push_back(e); else q7.push_back(e);
    cfg_num_nodes = 5'(num);
    cfg_out       = {oneg, 5'(osel)};
    if (d == 3) start3 = 1'b1; else start7 = 1'b1;
    tick();
    start3 = 1'b0;
    start7 = 1'b0;
    cfg_we = 1'b0;
    lat    = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if ((d == 3) ? valid3 : valid7) begin
        lat = c;
        break;
      end
    end
    chk($sformatf("latency_dut%0d", d), 128'(lat), 128'(elat));
  endtask

  task automatic drain(input int d);
    for (int c = 0; c < 40; c++) begin
      if (!((d == 3) ? busy3 : busy7)) break;
      tick();
    end
    chk($sformatf("drain_dut%0d", d), 128'((d == 3) ? busy3 : busy7), 128'(0));
  endtask

  function automatic logic sig_val(input int s, input int m, input logic nv[16]);
    if (s == 0) return 1'b0;
    if (s <= 7) return 1'((m >> (s - 1)) & 1);
    return nv[s - 8];
  endfunction

  // Per-minterm scalar evaluation of the programmed 7-input network.
  function automatic logic [127:0] model7(input int num, input int osel, input bit oneg);
    logic [127:0] r;
    logic         nv [16];
    logic         a, b, c;
    r = '0;
    for (int m = 0; m < 128; m++) begin
      nv = '{default: 1'b0};
      for (int k = 0; k < num; k++) begin
        a = sig_val(c_sel[k][0], m, nv) ^ c_neg[k][0];
        b = sig_val(c_sel[k][1], m, nv) ^ c_neg[k][1];
        c = sig_val(c_sel[k][2], m, nv) ^ c_neg[k][2];
        nv[k] = (a & b) | (a & c) | (b & c);
      end
      r[m] = sig_val(osel, m, nv) ^ oneg;
    end
    return r;
  endfunction

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_node = '0; cfg_num_nodes = '0;
    cfg_out = '0; start3 = 1'b0; start7 = 1'b0; tt_ready = 1'b1;
    repeat (3) tick();
    chk("rst_tt3", 128'(tt3), 128'(0));
    chk("rst_valid3", 128'(valid3), 128'(0));
    chk("rst_err3", 128'(err3), 128'(0));
    chk("rst_busy3", 128'(busy3), 128'(0));
    chk("rst_tt7", tt7, 128'(0));
    chk("rst_busy7", 128'(busy7), 128'(0));
    rst = 1'b0;
    tick();

    // Single-node functions on the 3-input engine.
    prog(0, 1, 2, 3, 0, 0, 0); run(3, 1, 4, 0, 128'(8'hE8), 0, 2); drain(3);
    prog(0, 1, 2, 3, 1, 0, 0); run(3, 1, 4, 0, 128'(8'hD4), 0, 2); drain(3);
    prog(0, 0, 1, 2, 0, 0, 0); run(3, 1, 4, 0, 128'(8'h88), 0, 2); drain(3);
    prog(0, 0, 1, 2, 1, 0, 0); run(3, 1, 4, 0, 128'(8'hEE), 0, 2); drain(3);
    prog(0, 1, 2, 3, 0, 0, 0); run(3, 1, 4, 1, 128'(8'h17), 0, 2); drain(3);

    // Zero-node runs: direct input, missing node, out-of-range selector.
    run(3, 0, 3, 0, 128'(8'hF0), 0, 1); drain(3);
    run(3, 0, 4, 0, 128'(8'h00), 1, 1); drain(3);
    run(3, 0, 31, 0, 128'(8'h00), 1, 1); drain(3);

    // Write and start in the same cycle: the new entry is evaluated.
    cfg_node = {3'b001, 5'd3, 5'd2, 5'd1}; cfg_addr = 4'd0; cfg_we = 1'b1;
    run(3, 1, 4, 0, 128'(8'hD4), 0, 2); drain(3);

    // Forward reference, held result, ignored start and write while busy.
    prog(0, 5, 1, 2, 0, 0, 0);
    tt_ready = 1'b0;
    run(3, 1, 4, 0, 128'(8'h88), 1, 2);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        start3 = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd0; cfg_node = {3'b000, 5'd3, 5'd2, 5'd1};
      end
      tick();
      start3 = 1'b0; cfg_we = 1'b0;
      chk("hold_tt3", 128'(tt3), 128'(8'h88));
      chk("hold_err3", 128'(err3), 128'(1));
      chk("hold_valid3", 128'(valid3), 128'(1));
      chk("hold_busy3", 128'(busy3), 128'(1));
    end
    tt_ready = 1'b1;
    drain(3);
    run(3, 1, 4, 0, 128'(8'h88), 1, 2); drain(3);

    // Node count above capacity saturates and flags an error.
    for (int k = 0; k < 16; k++) prog(k, 1, 2, 3, 0, 0, 0);
    run(3, 20, 19, 0, 128'(8'hE8), 1, 17); drain(3);

    // Six-node chain on the 7-input engine.
    prog(0, 1, 2, 3, 0, 0, 0);
    prog(1, 8, 4, 5, 0, 1, 0);
    prog(2, 9, 6, 7, 0, 0, 1);
    prog(3, 10, 8, 2, 1, 0, 0);
    prog(4, 11, 9, 0, 0, 0, 1);
    prog(5, 12, 10, 7, 0, 1, 0);
    run(7, 6, 13, 1, model7(6, 13, 1), 0, 7); drain(7);
    run(7, 6, 11, 0, model7(6, 11, 0), 0, 7); drain(7);

    // Reset during the third EVAL cycle aborts without a result.
    cfg_num_nodes = 5'd6; cfg_out = 6'd13; start7 = 1'b1;
    tick();
    start7 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("abort_busy7", 128'(busy7), 128'(0));
    chk("abort_valid7", 128'(valid7), 128'(0));
    chk("abort_tt7", tt7, 128'(0));
    chk("abort_err7", 128'(err7), 128'(0));
    rst = 1'b0;
    repeat (10) tick();
    chk("post_abort_valid7", 128'(valid7), 128'(0));
    chk("post_abort_busy7", 128'(busy7), 128'(0));

    chk("q3_empty", 128'(q3.size()), 128'(0));
    chk("q7_empty", 128'(q7.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
